// File: rtl/i2c_bus_monitor.sv
// Oversampling I2C bus monitor: synchronises and deglitches SCL/SDA, detects
// START / REPEATED START / STOP, and deserialises data bits, bytes and the ACK slot.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sck,
    input  logic       sda,
    input  logic       clear_seen,
    output logic       start_pulse,
    output logic       rstart_pulse,
    output logic       stop_pulse,
    output logic       bus_busy,
    output logic       bit_valid,
    output logic       bit_value,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       ack_valid,
    output logic       ack,
    output logic       framing_error,
    output logic       seen_start,
    output logic       seen_repeated_start,
    output logic       seen_stop
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_next;

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [CW-1:0]          cnt_q  [2];
    logic [1:0]             filt_q;
    logic [1:0]             prev_q;

    logic       pending, pending_v;
    logic [3:0] bit_idx;
    logic [7:0] shift_q;

    assign raw = {sda, sck};

    // Sync flops and filters reset to 1 so the bus looks idle out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '1;
                cnt_q[i]  <= '0;
            end
            filt_q <= 2'b11;
            prev_q <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= ~filt_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
            prev_q <= filt_q;
        end
    end

    logic scl_f, sda_f, scl_p, sda_p;
    logic scl_rise, scl_fall, scl_steady_hi;
    logic det_start, det_rstart, det_stop, det_any;

    assign scl_f = filt_q[0];
    assign sda_f = filt_q[1];
    assign scl_p = prev_q[0];
    assign sda_p = prev_q[1];

    assign scl_rise      = scl_f & ~scl_p;
    assign scl_fall      = ~scl_f & scl_p;
    assign scl_steady_hi = scl_f & scl_p;

    assign det_start  = scl_steady_hi & ~sda_f & sda_p & (state == IDLE);
    assign det_rstart = scl_steady_hi & ~sda_f & sda_p & (state == ACTIVE);
    assign det_stop   = scl_steady_hi & sda_f & ~sda_p;
    assign det_any    = det_start | det_rstart | det_stop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: default assigned first so every path drives state_next; no latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (det_start) state_next = ACTIVE;
            ACTIVE:  if (det_stop)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus_busy = (state == ACTIVE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_pulse         <= 1'b0;
            rstart_pulse        <= 1'b0;
            stop_pulse          <= 1'b0;
            framing_error       <= 1'b0;
            bit_valid           <= 1'b0;
            bit_value           <= 1'b0;
            byte_valid          <= 1'b0;
            byte_data           <= 8'h00;
            ack_valid           <= 1'b0;
            ack                 <= 1'b0;
            seen_start          <= 1'b0;
            seen_repeated_start <= 1'b0;
            seen_stop           <= 1'b0;
            pending             <= 1'b0;
            pending_v           <= 1'b0;
            bit_idx             <= 4'd0;
            shift_q             <= 8'h00;
        end else begin
            start_pulse   <= det_start;
            rstart_pulse  <= det_rstart;
            stop_pulse    <= det_stop;
            framing_error <= (det_rstart | det_stop) && (bit_idx != 4'd0);
            bit_valid     <= 1'b0;
            byte_valid    <= 1'b0;
            ack_valid     <= 1'b0;

            // NOTE: a new set takes priority over clear_seen in the same cycle.
            seen_start          <= det_start  | (seen_start & ~clear_seen);
            seen_repeated_start <= det_rstart | (seen_repeated_start & ~clear_seen);
            seen_stop           <= det_stop   | (seen_stop & ~clear_seen);

            if (det_any) begin
                // The SCL-high phase of a condition never becomes a data bit.
                pending_v <= 1'b0;
                bit_idx   <= 4'd0;
            end else if (state == ACTIVE) begin
                if (scl_rise) begin
                    pending   <= sda_f;
                    pending_v <= 1'b1;
                end else if (scl_fall && pending_v) begin
                    pending_v <= 1'b0;
                    bit_valid <= 1'b1;
                    bit_value <= pending;
                    if (bit_idx == 4'd8) begin
                        ack_valid <= 1'b1;
                        ack       <= ~pending;
                        bit_idx   <= 4'd0;
                    end else begin
                        shift_q <= {shift_q[6:0], pending};
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == 4'd7) begin
                            byte_valid <= 1'b1;
                            byte_data  <= {shift_q[6:0], pending};
                        end
                    end
                end
            end
        end
    end

endmodule
